// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int ZERO_IDX      = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for hazard detection, with busy lookups for two read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          ctrl_reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_reg,
  input  logic          issue,
  input  logic [AW-1:0] issue_reg,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] pending;
  logic             wr_eff;
  logic             iss_eff;

  assign wr_eff  = wr_en && !(ZERO_REG && wr_reg == AW'(ZERO_IDX));
  assign iss_eff = issue && !(ZERO_REG && issue_reg == AW'(ZERO_IDX));

  // The set follows the clear so a same-cycle issue (new producer) wins.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      pending <= '0;
    end else begin
      if (wr_eff)  pending[wr_reg]    <= 1'b0;
      if (iss_eff) pending[issue_reg] <= 1'b1;
    end
  end

  function automatic logic busy_of(input logic [AW-1:0] addr);
    logic b;
    b = pending[addr];
    if (BYPASS && wr_eff && wr_reg == addr && !(iss_eff && issue_reg == addr)) b = 1'b0;
    if (ZERO_REG && addr == AW'(ZERO_IDX)) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    busy_a = busy_of(rd_a);
    busy_b = busy_of(rd_b);
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with optional zero register, write bypass, 0/1-cycle reads,
// pending scoreboard and a debug tap window.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter bit ZERO_REG     = 1'b1,
  parameter bit BYPASS       = 1'b1,
  parameter int READ_LATENCY = 0,
  parameter int TAP_BASE     = 25,
  parameter int TAP_COUNT    = 5,
  localparam int AW          = clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       ctrl_writeEnable,
  input  logic [AW-1:0]              ctrl_writeReg,
  input  logic [WIDTH-1:0]           data_writeReg,
  input  logic [AW-1:0]              ctrl_readRegA,
  input  logic [AW-1:0]              ctrl_readRegB,
  output logic [WIDTH-1:0]           data_readRegA,
  output logic [WIDTH-1:0]           data_readRegB,
  input  logic                       ctrl_issue,
  input  logic [AW-1:0]              ctrl_issueReg,
  output logic                       busy_A,
  output logic                       busy_B,
  output logic [TAP_COUNT*WIDTH-1:0] data_tap
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_eff;

  assign wr_eff = ctrl_writeEnable && !(ZERO_REG && ctrl_writeReg == AW'(ZERO_IDX));

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_eff) begin
      mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  // fwd=1 returns the value the array holds once this cycle's write lands.
  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr, input bit fwd);
    logic [WIDTH-1:0] v;
    v = mem[addr];
    if (fwd && wr_eff && ctrl_writeReg == addr) v = data_writeReg;
    if (ZERO_REG && addr == AW'(ZERO_IDX)) v = '0;
    return v;
  endfunction

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      always_comb begin
        data_readRegA = read_word(ctrl_readRegA, BYPASS);
        data_readRegB = read_word(ctrl_readRegB, BYPASS);
      end
    end else begin : g_reg_read
      logic [WIDTH-1:0] rd_a_p1;
      logic [WIDTH-1:0] rd_b_p1;

      // Stage p1: post-write read data, independent of BYPASS.
      always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
          rd_a_p1 <= '0;
          rd_b_p1 <= '0;
        end else begin
          rd_a_p1 <= read_word(ctrl_readRegA, 1'b1);
          rd_b_p1 <= read_word(ctrl_readRegB, 1'b1);
        end
      end

      assign data_readRegA = rd_a_p1;
      assign data_readRegB = rd_b_p1;
    end
  endgenerate

  generate
    for (genvar g = 0; g < TAP_COUNT; g++) begin : g_tap
      assign data_tap[g*WIDTH +: WIDTH] = mem[TAP_BASE+g];
    end
  endgenerate

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .wr_en     (ctrl_writeEnable),
    .wr_reg    (ctrl_writeReg),
    .issue     (ctrl_issue),
    .issue_reg (ctrl_issueReg),
    .rd_a      (ctrl_readRegA),
    .rd_b      (ctrl_readRegB),
    .busy_a    (busy_A),
    .busy_b    (busy_B)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: default, no-bypass and registered-read instances.
module tb_regfile_sb;

  localparam int SEL_A0 = 0, SEL_B0 = 1, SEL_BA0 = 2, SEL_BB0 = 3, SEL_TAP = 4;
  localparam int SEL_NA = 5, SEL_NBA = 6, SEL_LA = 7, SEL_LB = 8;

  logic        clk = 1'b0;
  logic        rst_n, we, iss;
  logic [4:0]  wreg, ra, rb, ireg;
  logic [31:0] wdata;

  logic [31:0]  a0, b0, na, nb, la, lb;
  logic         ba0, bb0, nba, nbb, lba, lbb;
  logic [159:0] tap0, ntap, ltap;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clock(clk), .ctrl_reset(rst_n), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a0), .data_readRegB(b0), .ctrl_issue(iss), .ctrl_issueReg(ireg),
    .busy_A(ba0), .busy_B(bb0), .data_tap(tap0)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nbp (
    .clock(clk), .ctrl_reset(rst_n), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(na), .data_readRegB(nb), .ctrl_issue(iss), .ctrl_issueReg(ireg),
    .busy_A(nba), .busy_B(nbb), .data_tap(ntap)
  );

  regfile_sb #(.READ_LATENCY(1)) u_lat (
    .clock(clk), .ctrl_reset(rst_n), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(la), .data_readRegB(lb), .ctrl_issue(iss), .ctrl_issueReg(ireg),
    .busy_A(lba), .busy_B(lbb), .data_tap(ltap)
  );

  typedef struct {
    string        tag;
    int           sel;
    logic [159:0] val;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [159:0] observe(input int sel);
    case (sel)
      SEL_A0:  return {128'b0, a0};
      SEL_B0:  return {128'b0, b0};
      SEL_BA0: return {159'b0, ba0};
      SEL_BB0: return {159'b0, bb0};
      SEL_TAP: return tap0;
      SEL_NA:  return {128'b0, na};
      SEL_NBA: return {159'b0, nba};
      SEL_LA:  return {128'b0, la};
      SEL_LB:  return {128'b0, lb};
      default: return 'x;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [159:0] v, input int lat);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v; e.due = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t keep[$];
    logic [159:0] obs;
    foreach (sbq[i]) begin
      if (sbq[i].due <= cyc) begin
        obs = observe(sbq[i].sel);
        tests++;
        assert (obs === sbq[i].val) else begin
          fails++;
          $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", sbq[i].tag, cyc, obs, sbq[i].val);
        end
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  endtask

  task automatic cycle();
    #1;
    drain();
    @(posedge clk);
    cyc++;
    #1;
    drain();
  endtask

  logic [159:0] t;

  initial begin
    rst_n = 1'b0; we = 1'b0; iss = 1'b0;
    wreg = '0; ra = '0; rb = '0; ireg = '0; wdata = '0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset state on every address
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(31 - a);
      sb_push("rst_rdA", SEL_A0, 160'h0, 0);
      sb_push("rst_rdB", SEL_B0, 160'h0, 0);
      sb_push("rst_busyA", SEL_BA0, 160'h0, 0);
      sb_push("rst_busyB", SEL_BB0, 160'h0, 0);
      sb_push("rst_latA", SEL_LA, 160'h0, 1);
      if (a == 0) sb_push("rst_tap", SEL_TAP, 160'h0, 0);
      cycle();
    end

    // Plain write then read; zero register ignores writes
    we = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF; ra = 5'd1; rb = 5'd2;
    sb_push("wr5_other", SEL_A0, 160'h0, 0);
    cycle();
    we = 1'b0; ra = 5'd5; rb = 5'd0;
    sb_push("rd5_A", SEL_A0, 160'hDEADBEEF, 0);
    sb_push("rd0_B", SEL_B0, 160'h0, 0);
    sb_push("rd5_nbp", SEL_NA, 160'hDEADBEEF, 0);
    cycle();
    we = 1'b1; wreg = 5'd0; wdata = 32'h1234; ra = 5'd0;
    sb_push("wr0_bypass", SEL_A0, 160'h0, 0);
    cycle();
    we = 1'b0;
    sb_push("rd0_after", SEL_A0, 160'h0, 0);
    sb_push("rd0_lat", SEL_LA, 160'h0, 1);
    cycle();

    // Same-cycle bypass vs no bypass
    we = 1'b1; wreg = 5'd7; wdata = 32'hA5A5A5A5; ra = 5'd7; rb = 5'd7;
    sb_push("byp7_A", SEL_A0, 160'hA5A5A5A5, 0);
    sb_push("byp7_B", SEL_B0, 160'hA5A5A5A5, 0);
    sb_push("nbp7_old", SEL_NA, 160'h0, 0);
    sb_push("lat7_post", SEL_LA, 160'hA5A5A5A5, 1);
    cycle();
    we = 1'b0;
    sb_push("nbp7_new", SEL_NA, 160'hA5A5A5A5, 0);
    cycle();

    // Scoreboard: issue, write clears with bypass, issue+write keeps pending
    iss = 1'b1; ireg = 5'd9; ra = 5'd0;
    cycle();
    iss = 1'b0; ra = 5'd9; rb = 5'd9;
    sb_push("iss9_busyA", SEL_BA0, 160'h1, 0);
    sb_push("iss9_busyB", SEL_BB0, 160'h1, 0);
    sb_push("iss9_nbp", SEL_NBA, 160'h1, 0);
    cycle();
    we = 1'b1; wreg = 5'd9; wdata = 32'h55;
    sb_push("wr9_byp_busy", SEL_BA0, 160'h0, 0);
    sb_push("wr9_nbp_busy", SEL_NBA, 160'h1, 0);
    cycle();
    we = 1'b0;
    sb_push("wr9_after_busy", SEL_BA0, 160'h0, 0);
    sb_push("wr9_after_nbp", SEL_NBA, 160'h0, 0);
    sb_push("wr9_data", SEL_A0, 160'h55, 0);
    cycle();
    we = 1'b1; wreg = 5'd9; wdata = 32'h66; iss = 1'b1; ireg = 5'd9;
    sb_push("isswr9_data", SEL_A0, 160'h66, 0);
    cycle();
    we = 1'b0; iss = 1'b0;
    sb_push("isswr9_busy", SEL_BA0, 160'h1, 0);
    sb_push("isswr9_stored", SEL_A0, 160'h66, 0);
    cycle();
    iss = 1'b1; ireg = 5'd0; ra = 5'd0;
    sb_push("iss0_busy", SEL_BA0, 160'h0, 0);
    cycle();
    iss = 1'b0;
    sb_push("iss0_busy_after", SEL_BA0, 160'h0, 0);
    cycle();

    // Registered reads and mid-stream reset
    we = 1'b1; wreg = 5'd3; wdata = 32'h77; ra = 5'd3; rb = 5'd9;
    sb_push("lat3_one_cycle", SEL_LA, 160'h77, 1);
    sb_push("lat9_B", SEL_LB, 160'h66, 1);
    cycle();
    rst_n = 1'b0; we = 1'b1; wreg = 5'd12; wdata = 32'hCAFE; iss = 1'b1; ireg = 5'd13;
    sb_push("lat_rst_out", SEL_LA, 160'h0, 1);
    cycle();
    rst_n = 1'b1; we = 1'b0; iss = 1'b0; ra = 5'd12; rb = 5'd9;
    sb_push("rst_wr12_drop", SEL_A0, 160'h0, 0);
    sb_push("rst_pend9_clr", SEL_BB0, 160'h0, 0);
    sb_push("rst_mem9_clr", SEL_B0, 160'h0, 0);
    cycle();
    ra = 5'd13; rb = 5'd5;
    sb_push("rst_iss13_drop", SEL_BA0, 160'h0, 0);
    sb_push("rst_mem5_clr", SEL_B0, 160'h0, 0);
    cycle();

    // Tap window: each register appears one cycle after its write
    t = '0;
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; wreg = 5'(25 + i); wdata = 32'h11 + 32'(i);
      sb_push("tap_before", SEL_TAP, t, 0);
      t[i*32 +: 32] = 32'h11 + 32'(i);
      sb_push("tap_after", SEL_TAP, t, 1);
      cycle();
    end
    we = 1'b0;
    sb_push("tap_final", SEL_TAP, {32'h15, 32'h14, 32'h13, 32'h12, 32'h11}, 0);
    cycle();

    tests++;
    assert (sbq.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover: observed=%0d expected=0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Generalised width and depth, with an optional hard-wired zero register.
- Adds write-to-read bypass, selectable 0- or 1-cycle read latency, a per-register pending (scoreboard) bit for pipeline hazard detection, and a parametrised debug tap window.
- Sits between decode (reads, issue) and writeback (writes) in the pipelined core.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers. Power of two, >= 2. AW = clog2(DEPTH).
- ZERO_REG, 1, register 0 always reads 0, ignores writes, is never pending.
- BYPASS, 1, a same-cycle write is forwarded to read ports and busy flags.
- READ_LATENCY, 0, 0 = combinational reads, 1 = registered reads.
- TAP_BASE, 25, first register exposed on data_tap.
- TAP_COUNT, 5, number of consecutive registers exposed. TAP_BASE+TAP_COUNT <= DEPTH.

Ports:
- clock  in  1  sole clock, rising edge.
- ctrl_reset  in  1  synchronous, active-low reset.
- ctrl_writeEnable  in  1  writeback strobe.
- ctrl_writeReg  in  AW  write address.
- data_writeReg  in  WIDTH  write data.
- ctrl_readRegA  in  AW  read port A address.
- ctrl_readRegB  in  AW  read port B address.
- data_readRegA  out  WIDTH  read port A data.
- data_readRegB  out  WIDTH  read port B data.
- ctrl_issue  in  1  marks a destination register as pending.
- ctrl_issueReg  in  AW  destination of the issued instruction.
- busy_A  out  1  pending status of ctrl_readRegA.
- busy_B  out  1  pending status of ctrl_readRegB.
- data_tap  out  TAP_COUNT*WIDTH  registers TAP_BASE..TAP_BASE+TAP_COUNT-1, lowest register in the LSBs.

Behaviour:
- Reset: on a rising edge with ctrl_reset=0, all registers go to 0 and all pending bits clear. Writes and issues in that cycle are ignored. With READ_LATENCY=1 the registered read outputs also go to 0.
- Write: on a rising edge with ctrl_writeEnable=1, mem[ctrl_writeReg] <= data_writeReg and pending[ctrl_writeReg] <= 0. With ZERO_REG=1 a write to register 0 is a no-op.
- Issue: on a rising edge with ctrl_issue=1, pending[ctrl_issueReg] <= 1. With ZERO_REG=1, issue to register 0 is a no-op.
- Issue and write to the same register in the same cycle: the data is stored and pending ends at 1, because the new producer wins.
- READ_LATENCY=0:
  - data_readRegX = mem[addr] combinationally.
  - If BYPASS=1, ctrl_writeEnable=1 and ctrl_writeReg==addr (not zero register), data_writeReg is returned instead.
  - Both ports may read the same address.
- READ_LATENCY=1: read data is captured at the edge and presented the next cycle. The captured value is the post-write contents, i.e. it includes the write on that edge regardless of BYPASS.
- Busy:
  - busy_X = pending[addr], combinational, for both latencies.
  - If BYPASS=1 and a write to addr occurs this cycle with no same-cycle issue to addr, busy_X = 0.
  - Register 0 is never busy when ZERO_REG=1.
- Tap: reflects stored contents only, with no bypass. It updates the cycle after a write.
- Reset takes priority over all other inputs. Asserting ctrl_reset mid-stream discards in-flight writes, issues and pending state in that cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default WIDTH/DEPTH constants;
  - the AW clog2 function;
  - the zero-register index constant.
- One sub-module: regfile_scoreboard. It holds the DEPTH pending bits, the set/clear/priority logic, and the two busy lookups with bypass masking.

Test Plan:
- Reset with ctrl_reset=0 for 2 cycles, then read all addresses -> every data_readRegX=0, busy=0, data_tap all 0.
- Write 0xDEADBEEF to r5, then read A=r5, B=r0 the next cycle -> A=0xDEADBEEF, B=0. Also write 0x1234 to r0, then read r0 -> 0.
- BYPASS=1, LAT=0: write 0xA5A5A5A5 to r7 while reading A=r7 in the same cycle -> A=0xA5A5A5A5 that cycle. With BYPASS=0 -> A shows the old value 0 that cycle.
- Issue r9, then read r9 -> busy_A=1. Write r9 with 0x55 in a later cycle -> busy_A=0 in that cycle (bypass), stays 0 after. Issue and write r9 in the same cycle -> pending remains 1.
- LAT=1: write 0x77 to r3 and read r3 in the same cycle -> data_readRegA=0x77 exactly one cycle later. Apply ctrl_reset=0 next -> output 0 the following cycle.
- Write 0x11..0x15 into r25..r29 -> data_tap = {0x15,0x14,0x13,0x12,0x11} (r29 in the MSBs, r25 in the LSBs), each register updating one cycle after its write.
